// File: rtl/mod_sub_serial_if.sv
// Operand/result bundle for the digit-serial modular subtractor.
interface mod_sub_serial_if #(
    parameter int K = 32
);
    logic         start;
    logic [K-1:0] a;
    logic [K-1:0] b;
    logic [K-1:0] m;
    logic         busy;
    logic         done;
    logic [K-1:0] result;

    modport master (
        output start, a, b, m,
        input  busy, done, result
    );

    modport slave (
        input  start, a, b, m,
        output busy, done, result
    );
endinterface

// File: rtl/mod_sub_serial.sv
// Digit-serial (a - b) mod m: W-bit subtract pass, optional W-bit add-back pass of m.
// Latency start->done: N+1 cycles without borrow, 2N+1 with borrow.
// No backpressure: start is only sampled in IDLE, otherwise dropped.
module mod_sub_serial #(
    parameter int K = 32,
    parameter int W = 8
) (
    input  logic              clk,
    input  logic              rst,
    mod_sub_serial_if.slave   bus
);
    localparam int N  = K / W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [K-1:0]  a_sr;
    logic [K-1:0]  b_sr;
    logic [K-1:0]  m_sr;
    logic [K-1:0]  p_sr;
    logic [K-1:0]  result_q;
    logic          cy;
    logic [CW-1:0] cnt;

    logic          last;
    logic [W:0]    d_sub;
    logic [W:0]    d_add;
    logic [K-1:0]  p_sub;
    logic [K-1:0]  p_add;

    assign last  = (cnt == CW'(N - 1));
    assign d_sub = {1'b0, a_sr[W-1:0]} - {1'b0, b_sr[W-1:0]} - {{W{1'b0}}, cy};
    assign d_add = {1'b0, p_sr[W-1:0]} + {1'b0, m_sr[W-1:0]} + {{W{1'b0}}, cy};

    // Digits leave from the bottom and re-enter at the top, so after N
    // cycles every digit is back in its own position.
    assign p_sub = {d_sub[W-1:0], p_sr[K-1:W]};
    assign p_add = {d_add[W-1:0], p_sr[K-1:W]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = SUB;
            SUB:  if (last) state_nxt = d_sub[W] ? FIX : DONE;
            FIX:  if (last) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr     <= '0;
            b_sr     <= '0;
            m_sr     <= '0;
            p_sr     <= '0;
            result_q <= '0;
            cy       <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr <= bus.a;
                        b_sr <= bus.b;
                        m_sr <= bus.m;
                        cy   <= 1'b0;
                        cnt  <= '0;
                    end
                end
                SUB: begin
                    a_sr <= a_sr >> W;
                    b_sr <= b_sr >> W;
                    p_sr <= p_sub;
                    if (last) begin
                        // A final borrow hands over to FIX with the carry cleared.
                        cy  <= 1'b0;
                        cnt <= '0;
                        if (!d_sub[W]) result_q <= p_sub;
                    end else begin
                        cy  <= d_sub[W];
                        cnt <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    m_sr <= m_sr >> W;
                    p_sr <= p_add;
                    if (last) begin
                        // Carry-out is dropped: it cancels the pass-1 borrow.
                        cy       <= 1'b0;
                        cnt      <= '0;
                        result_q <= p_add;
                    end else begin
                        cy  <= d_add[W];
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state == SUB) || (state == FIX);
    assign bus.done   = (state == DONE);
    assign bus.result = result_q;
endmodule
